// File: rtl/pdua_useq.sv
// ---------------------------------------------------------------------------
// pdua_useq -- microprogram sequencer
//
// Sits directly behind the instruction register. It builds the control-ROM
// address as {bank, opcode field, step}. It runs the fetch, execute and
// interrupt-entry micro-routines. Conditional micro-jumps are resolved
// against the ALU flags.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (has priority over hold)
//   opcode     opcode from IR, valid from the cycle after ir_ena
//   hold       wait state: state/step/uerr frozen, strobes forced low
//   flag_z/n/c/p  ALU zero / negative / carry / overflow flags
//   int_req    interrupt request (level)
//   int_en     interrupt enable from the status register
//   u_end      ROM field: last micro-step of this instruction
//   u_cond     ROM field: jump condition select
//   u_jstep    ROM field: jump target step within the current routine
//   uaddr      microprogram ROM address
//   ir_ena     IR load enable
//   ir_sclr    IR synchronous clear
//   int_ack    interrupt acknowledge pulse
//   uerr       sticky illegal-sequence flag (step overflow in EXEC)
// ---------------------------------------------------------------------------
module pdua_useq #(
    parameter int OPC_W     = 5,
    parameter int STEP_W    = 3,
    parameter int FETCH_LEN = 3,
    parameter int INT_LEN   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPC_W-1:0]          opcode,
    input  logic                      hold,
    input  logic                      flag_z,
    input  logic                      flag_n,
    input  logic                      flag_c,
    input  logic                      flag_p,
    input  logic                      int_req,
    input  logic                      int_en,
    input  logic                      u_end,
    input  logic [2:0]                u_cond,
    input  logic [STEP_W-1:0]         u_jstep,
    output logic [OPC_W+STEP_W:0]     uaddr,
    output logic                      ir_ena,
    output logic                      ir_sclr,
    output logic                      int_ack,
    output logic                      uerr
);

    localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(FETCH_LEN - 1);
    localparam logic [STEP_W-1:0] INT_LAST   = STEP_W'(INT_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_LAST  = {STEP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_INTR  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [STEP_W-1:0]   step_reg,  step_next;
    logic                uerr_reg,  uerr_next;

    // -----------------------------------------------------------------------
    // Jump condition decode. Each u_cond code selects one term of cond_vec.
    // Codes 0 and 7 (reserved) never jump, 6 always jumps.
    // -----------------------------------------------------------------------
    logic [7:0] cond_vec;
    logic [7:0] cond_hit;
    logic       cond_true;

    assign cond_vec = {1'b0, 1'b1, flag_p, flag_c, flag_n, ~flag_z, flag_z, 1'b0};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cond
            assign cond_hit[gi] = cond_vec[gi] & (u_cond == 3'(gi));
        end
    endgenerate

    assign cond_true = |cond_hit;

    // -----------------------------------------------------------------------
    // Next-state logic. While hold is high every register keeps its value.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        uerr_next  = uerr_reg;
        if (!hold) begin
            case (state_reg)
                S_CLR: begin
                    state_next = S_FETCH;
                    step_next  = '0;
                end
                S_FETCH: begin
                    // ROM fields are don't-care during fetch.
                    if (step_reg == FETCH_LAST) begin
                        state_next = S_EXEC;
                        step_next  = '0;
                    end else begin
                        step_next  = step_reg + STEP_ONE;
                    end
                end
                S_EXEC: begin
                    if (u_end) begin
                        // Instruction boundary: the only point where an
                        // interrupt can be taken.
                        step_next  = '0;
                        state_next = (int_req && int_en) ? S_INTR : S_FETCH;
                    end else if (cond_true) begin
                        step_next  = u_jstep;
                    end else if (step_reg == STEP_LAST) begin
                        // Routine ran off its end without u_end: flag it and
                        // recover by fetching the next instruction.
                        uerr_next  = 1'b1;
                        step_next  = '0;
                        state_next = S_FETCH;
                    end else begin
                        step_next  = step_reg + STEP_ONE;
                    end
                end
                S_INTR: begin
                    // int_req is deliberately not looked at here.
                    if (step_reg == INT_LAST) begin
                        state_next = S_FETCH;
                        step_next  = '0;
                    end else begin
                        step_next  = step_reg + STEP_ONE;
                    end
                end
                default: begin
                    state_next = S_CLR;
                    step_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_CLR;
            step_reg  <= '0;
            uerr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            uerr_reg  <= uerr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: combinational from registered state/step (plus opcode in
    // EXEC). Strobes are suppressed during hold; uaddr is not, since the
    // frozen state already keeps it stable.
    // -----------------------------------------------------------------------
    always_comb begin
        uaddr   = '0;
        ir_ena  = 1'b0;
        ir_sclr = 1'b0;
        int_ack = 1'b0;
        case (state_reg)
            S_CLR: begin
                uaddr   = '0;
                ir_ena  = ~hold;
                ir_sclr = ~hold;
            end
            S_FETCH: begin
                uaddr  = {1'b1, {OPC_W{1'b0}}, step_reg};
                ir_ena = ~hold & (step_reg == FETCH_LAST);
            end
            S_EXEC: begin
                uaddr  = {1'b0, opcode, step_reg};
            end
            S_INTR: begin
                uaddr   = {1'b1, OPC_W'(1), step_reg};
                int_ack = ~hold & (step_reg == '0);
            end
            default: begin
                uaddr = '0;
            end
        endcase
    end

    assign uerr = uerr_reg;

endmodule

// File: doc/pdua_useq.md
Name: pdua_useq

Overview:
- Microprogram sequencer that sits directly downstream of the instruction register. It consumes the 5-bit opcode the IR produces and drives the IR's load and clear strobes.
- Generates the microprogram ROM address as {bank bit, opcode field, step}. Sequences the fetch, execute and interrupt micro-routines.
- Resolves conditional micro-jumps against the ALU flags.
- The control ROM itself is external. Its end, condition and jump-target fields feed back into this block.

Parameters:
- OPC_W, 5, opcode width (matches IR opcode output)
- STEP_W, 3, micro-step counter width (8 steps per routine)
- FETCH_LEN, 3, number of fetch micro-steps (1..2^STEP_W)
- INT_LEN, 4, number of interrupt-entry micro-steps (1..2^STEP_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- opcode  in  OPC_W  opcode from IR, valid from the cycle after ir_ena
- hold  in  1  freeze sequencer (wait state); all state held
- flag_z, flag_n, flag_c, flag_p  in  1 each  ALU zero/negative/carry/overflow flags
- int_req  in  1  interrupt request (level)
- int_en  in  1  interrupt enable from status register
- u_end  in  1  ROM field: last micro-step of this instruction
- u_cond  in  3  ROM field: jump condition select
- u_jstep  in  STEP_W  ROM field: jump target step within current routine
- uaddr  out  1+OPC_W+STEP_W  microprogram ROM address
- ir_ena  out  1  IR load enable
- ir_sclr  out  1  IR synchronous clear
- int_ack  out  1  interrupt acknowledge pulse
- uerr  out  1  sticky illegal-sequence flag

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: state=CLR, step=0, uerr=0, int_ack=0. Outputs in CLR: ir_ena=1, ir_sclr=1, uaddr=0.
- States and uaddr mapping:
  - CLR: uaddr=0.
  - FETCH: uaddr={1, 0…0, step}.
  - EXEC: uaddr={0, opcode, step}.
  - INTR: uaddr={1, 0…01, step}.
- CLR: lasts exactly 1 cycle and clears the IR. Next state FETCH, step=0. A reset asserted mid-routine re-enters CLR on the next edge regardless of state or hold.
- FETCH:
  - step increments each cycle.
  - ir_ena=1, ir_sclr=0 only when step==FETCH_LEN-1. The IR captures busC on that edge.
  - Next state EXEC, step=0.
  - u_end, u_cond and u_jstep are ignored.
- EXEC: ROM fields are evaluated each cycle, in priority order:
  - (1) u_end=1: step<=0. Next state is INTR if int_req&int_en, otherwise FETCH.
  - (2) condition true: step<=u_jstep.
  - (3) otherwise step<=step+1.
- u_cond encoding:
  - 0 = never
  - 1 = Z
  - 2 = !Z
  - 3 = N
  - 4 = C
  - 5 = P
  - 6 = always
  - 7 = never (reserved)
- Flags are sampled combinationally in the same cycle as the ROM word.
- Step overflow: in EXEC, step==2^STEP_W-1 with u_end=0 and no taken jump:
  - uerr<=1, sticky until rst.
  - step<=0, next state FETCH.
  - No wrap within EXEC.
- INTR:
  - int_ack=1 only on the first cycle (step==0).
  - step increments each cycle. At step==INT_LEN-1: next state FETCH, step<=0.
  - int_req is not re-sampled inside INTR.
- hold=1:
  - state, step and uerr are frozen. uaddr keeps its value.
  - ir_ena, ir_sclr and int_ack are forced to 0.
  - rst has priority over hold.
- Outputs ir_ena, ir_sclr, int_ack and uaddr are combinational from registered state/step (plus opcode in EXEC). Latency: opcode-to-uaddr is 0 cycles. Registers update on the rising edge.
- Interrupts are taken only at instruction boundaries (u_end), never mid-fetch.

Test Plan:
- Reset then run:
  - rst high 2 cycles, then low.
  - Required: one cycle with ir_sclr=ir_ena=1 and uaddr=0.
  - Then uaddr=0x100, 0x101, 0x102 with ir_ena=1 at 0x102.
  - Next cycle uaddr={0, opcode, 000}.
- Straight-line execute:
  - opcode=5'b00110; u_end=1 at step 2.
  - Required: uaddr 0x030, 0x031, 0x032, then back to 0x100.
- Conditional jump:
  - opcode=5'b01000, step 1 has u_cond=1, u_jstep=5.
  - With flag_z=1: next uaddr=0x045. With flag_z=0: next uaddr=0x042.
  - u_cond=7 never jumps.
- Interrupt entry:
  - int_req=int_en=1 when u_end=1.
  - Required: next uaddr=0x108 with int_ack=1 for exactly one cycle.
  - Then 0x109, 0x10A, 0x10B, then 0x100.
  - With int_en=0: goes directly to 0x100.
- Overflow and hold:
  - EXEC runs to step 7 with u_end=0.
  - Required: uerr=1 and FETCH entered; uerr stays 1 until rst.
  - hold=1 for 3 cycles mid-EXEC: uaddr constant and ir_ena=0; sequence resumes unchanged after hold drops.
- Reset mid-operation:
  - rst asserted during INTR step 2 with hold=1.
  - Required: next cycle state CLR, uaddr=0, uerr=0.
